// File: rtl/adc_ltc2308_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ltc2308_ctrl
//  Description : Single-request conversion controller for the LTC2308 8-channel
//                12-bit ADC. Each request pulses CONVST, then runs one 12-bit
//                serial frame. The frame sends the 6-bit configuration word
//                for the requested channel and reads back the result of the
//                previous conversion. The ADC pipelines one frame deep, so the
//                first frame after reset only primes it and is not reported.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50    in   system clock; all logic on its rising edge
//    RESET       in   asynchronous active-high reset
//    start       in   conversion request (sampled only while idle)
//    ch[2:0]     in   single-ended channel, captured with start
//    busy        out  request in progress (CONV and SHIFT)
//    data_valid  out  one-cycle strobe qualifying data/data_ch
//    data[11:0]  out  conversion result, straight binary
//    data_ch     out  channel that data belongs to
//    ADC_CONVST  out  ADC convert-start (also drives CS_N at top level)
//    ADC_SCLK    out  serial clock
//    ADC_DIN     out  serial configuration to the ADC
//    ADC_DOUT    in   serial result from the ADC
// ============================================================================
module adc_ltc2308_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        start,
    input  logic [2:0]  ch,
    output logic        busy,
    output logic        data_valid,
    output logic [11:0] data,
    output logic [2:0]  data_ch,
    output logic        ADC_CONVST,
    output logic        ADC_SCLK,
    output logic        ADC_DIN,
    input  logic        ADC_DOUT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CONV  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [9:0] c_CONV_LAST = 10'(CONV_CYCLES - 1);
    localparam logic [7:0] c_DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [3:0] c_BIT_LAST  = 4'd11;

    state_t      state_q,   state_d;
    logic [9:0]  conv_cnt_q, conv_cnt_d;
    logic [7:0]  div_cnt_q, div_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic        sclk_q,    sclk_d;
    logic [5:0]  cfg_sr_q,  cfg_sr_d;
    logic [11:0] shift_q,   shift_d;
    logic [2:0]  cfg_ch_q,  cfg_ch_d;
    logic [2:0]  last_ch_q, last_ch_d;
    logic [11:0] data_q,    data_d;
    logic [2:0]  data_ch_q, data_ch_d;
    logic        valid_q,   valid_d;
    logic        prime_q,   prime_d;
    logic        convst_q,  convst_d;

    // Config word: S/D, O/S, S1, S0, UNI, SLP (MSB first on the wire).
    logic [5:0]  w_cfg_word;
    assign w_cfg_word = {1'b1, cfg_ch_q[0], cfg_ch_q[2], cfg_ch_q[1], 1'b1, 1'b0};

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            conv_cnt_q <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            cfg_sr_q   <= '0;
            shift_q    <= '0;
            cfg_ch_q   <= '0;
            last_ch_q  <= '0;
            data_q     <= '0;
            data_ch_q  <= '0;
            valid_q    <= 1'b0;
            prime_q    <= 1'b0;
            convst_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            conv_cnt_q <= conv_cnt_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            sclk_q     <= sclk_d;
            cfg_sr_q   <= cfg_sr_d;
            shift_q    <= shift_d;
            cfg_ch_q   <= cfg_ch_d;
            last_ch_q  <= last_ch_d;
            data_q     <= data_d;
            data_ch_q  <= data_ch_d;
            valid_q    <= valid_d;
            prime_q    <= prime_d;
            convst_q   <= convst_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        div_cnt_d  = div_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        sclk_d     = sclk_q;
        cfg_sr_d   = cfg_sr_q;
        shift_d    = shift_q;
        cfg_ch_d   = cfg_ch_q;
        last_ch_d  = last_ch_q;
        data_d     = data_q;
        data_ch_d  = data_ch_q;
        valid_d    = 1'b0;
        prime_d    = prime_q;
        convst_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_ch_d   = ch;
                    conv_cnt_d = '0;
                    convst_d   = 1'b1;
                    state_d    = S_CONV;
                end
            end

            S_CONV: begin
                if (conv_cnt_q == c_CONV_LAST) begin
                    conv_cnt_d = '0;
                    div_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    sclk_d     = 1'b0;
                    // First config bit is on DIN before the first SCLK rise.
                    cfg_sr_d   = w_cfg_word;
                    state_d    = S_SHIFT;
                end else begin
                    conv_cnt_d = conv_cnt_q + 10'd1;
                    convst_d   = 1'b1;
                end
            end

            S_SHIFT: begin
                if (div_cnt_q == c_DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = ~sclk_q;
                    if (!sclk_q) begin
                        // Sample on the edge that raises SCLK.
                        shift_d = {shift_q[10:0], ADC_DOUT};
                    end else if (bit_cnt_q == c_BIT_LAST) begin
                        // End of frame: result belongs to the previous request.
                        cfg_sr_d  = '0;
                        data_d    = shift_q;
                        data_ch_d = last_ch_q;
                        last_ch_d = cfg_ch_q;
                        valid_d   = prime_q;
                        prime_d   = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        // Falling edge: advance DIN to the next config bit
                        // (zeros fill in after the six config bits).
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        cfg_sr_d  = {cfg_sr_q[4:0], 1'b0};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q == S_CONV) || (state_q == S_SHIFT);
    assign data_valid = valid_q;
    assign data       = data_q;
    assign data_ch    = data_ch_q;
    assign ADC_CONVST = convst_q;
    assign ADC_SCLK   = sclk_q;
    assign ADC_DIN    = cfg_sr_q[5];

endmodule
`default_nettype wire

// File: tb/tb_adc_ltc2308_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_ltc2308_ctrl
//  Description : Self-checking bench for adc_ltc2308_ctrl. Instance 0 uses the
//                default timing, instance 1 uses CLK_DIV=1, CONV_CYCLES=1.
//                A simple ADC model per instance shifts a 12-bit word out on
//                ADC_DOUT, changing only while ADC_SCLK is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_ltc2308_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance 0 (defaults)
    logic        start0 = 1'b0;
    logic [2:0]  ch0 = 3'd0;
    logic        busy0, dv0, convst0, sclk0, din0;
    logic [11:0] data0;
    logic [2:0]  dch0;
    logic        dout0 = 1'b0;
    logic [11:0] word0 = 12'h000;
    int          idx0 = 0;

    // Instance 1 (fast)
    logic        start1 = 1'b0;
    logic [2:0]  ch1 = 3'd0;
    logic        busy1, dv1, convst1, sclk1, din1;
    logic [11:0] data1;
    logic [2:0]  dch1;
    logic        dout1 = 1'b0;
    logic [11:0] word1 = 12'h000;
    int          idx1 = 0;

    adc_ltc2308_ctrl dut0 (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .start      (start0),
        .ch         (ch0),
        .busy       (busy0),
        .data_valid (dv0),
        .data       (data0),
        .data_ch    (dch0),
        .ADC_CONVST (convst0),
        .ADC_SCLK   (sclk0),
        .ADC_DIN    (din0),
        .ADC_DOUT   (dout0)
    );

    adc_ltc2308_ctrl #(.CLK_DIV(1), .CONV_CYCLES(1)) dut1 (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .start      (start1),
        .ch         (ch1),
        .busy       (busy1),
        .data_valid (dv1),
        .data       (data1),
        .data_ch    (dch1),
        .ADC_CONVST (convst1),
        .ADC_SCLK   (sclk1),
        .ADC_DIN    (din1),
        .ADC_DOUT   (dout1)
    );

    // ADC models: MSB presented when CONVST falls, next bit on each SCLK fall.
    always @(negedge convst0) begin
        idx0  = 0;
        dout0 = word0[11];
    end
    always @(negedge sclk0) begin
        idx0  = idx0 + 1;
        dout0 = (idx0 < 12) ? word0[11 - idx0] : 1'b0;
    end
    always @(negedge convst1) begin
        idx1  = 0;
        dout1 = word1[11];
    end
    always @(negedge sclk1) begin
        idx1  = idx1 + 1;
        dout1 = (idx1 < 12) ? word1[11 - idx1] : 1'b0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: actual %0h required %0h", name, idx, act, exp);
        end
    endtask

    // One request on the chosen instance; measures the frame from the accept
    // edge to the DONE cycle (first cycle with busy low again).
    task automatic run_frame(input int inst, input logic [2:0] c, input logic [11:0] w,
                             output int lat, output int nconv, output int nrise,
                             output int nhigh, output logic [11:0] din_bits,
                             output logic dv, output logic [11:0] d, output logic [2:0] dc);
        logic prev_sclk, s_busy, s_sclk, s_din, s_conv;
        lat = -1; nconv = 0; nrise = 0; nhigh = 0;
        din_bits = '0; dv = 1'b0; d = '0; dc = '0;
        prev_sclk = 1'b0;
        @(negedge clk);
        if (inst == 0) begin start0 = 1'b1; ch0 = c; word0 = w; end
        else           begin start1 = 1'b1; ch1 = c; word1 = w; end
        for (int cyc = 1; cyc <= 1000; cyc++) begin
            @(negedge clk);
            s_busy = (inst == 0) ? busy0   : busy1;
            s_sclk = (inst == 0) ? sclk0   : sclk1;
            s_din  = (inst == 0) ? din0    : din1;
            s_conv = (inst == 0) ? convst0 : convst1;
            if (s_conv) nconv++;
            if (s_sclk) nhigh++;
            if (s_sclk && !prev_sclk) begin
                nrise++;
                din_bits = {din_bits[10:0], s_din};
            end
            prev_sclk = s_sclk;
            // Channel changes mid-frame must not disturb the frame.
            if (cyc == 1) begin
                if (inst == 0) begin start0 = 1'b0; ch0 = ~c; end
                else           begin start1 = 1'b0; ch1 = ~c; end
            end
            if (!s_busy) begin
                lat = cyc;
                dv  = (inst == 0) ? dv0   : dv1;
                d   = (inst == 0) ? data0 : data1;
                dc  = (inst == 0) ? dch0  : dch1;
                break;
            end
        end
    endtask

    typedef struct {
        int          inst;
        logic [2:0]  ch;
        logic [11:0] word;
        logic        exp_valid;
        logic [11:0] exp_data;
        logic [2:0]  exp_ch;
        logic [5:0]  exp_cfg;
        int          exp_lat;
        int          exp_convst;
        int          exp_high;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat, nconv, nrise, nhigh;
        logic [11:0] din_bits, d;
        logic        dv;
        logic [2:0]  dc;
        int          rises;
        int          dv_pos[4];
        logic [2:0]  dv_ch[4];
        logic [2:0]  exp_b2b_ch[4];
        int          ndv, nlow;

        vecs[0] = '{0, 3'd3, 12'h123, 1'b0, 12'h000, 3'd0, 6'b110110, 129, 80, 24};
        vecs[1] = '{0, 3'd5, 12'hA5C, 1'b1, 12'hA5C, 3'd3, 6'b111010, 129, 80, 24};
        vecs[2] = '{0, 3'd6, 12'h5A3, 1'b1, 12'h5A3, 3'd5, 6'b101110, 129, 80, 24};
        vecs[3] = '{0, 3'd0, 12'hFFF, 1'b1, 12'hFFF, 3'd6, 6'b100010, 129, 80, 24};
        vecs[4] = '{0, 3'd7, 12'h000, 1'b1, 12'h000, 3'd0, 6'b111110, 129, 80, 24};
        vecs[5] = '{0, 3'd1, 12'h801, 1'b1, 12'h801, 3'd7, 6'b110010, 129, 80, 24};
        vecs[6] = '{1, 3'd2, 12'h3C3, 1'b0, 12'h000, 3'd0, 6'b100110, 26, 1, 12};
        vecs[7] = '{1, 3'd4, 12'hFFF, 1'b1, 12'hFFF, 3'd2, 6'b101010, 26, 1, 12};
        vecs[8] = '{1, 3'd7, 12'h000, 1'b1, 12'h000, 3'd4, 6'b111110, 26, 1, 12};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outs0", 0, {busy0, dv0, data0, dch0, convst0, sclk0, din0}, 0);
        check("rst_outs1", 0, {busy1, dv1, data1, dch1, convst1, sclk1, din1}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_outs0", 0, {busy0, dv0, data0, dch0, convst0, sclk0, din0}, 0);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            run_frame(vecs[i].inst, vecs[i].ch, vecs[i].word,
                      lat, nconv, nrise, nhigh, din_bits, dv, d, dc);
            check("latency", i, lat, vecs[i].exp_lat);
            check("convst_cycles", i, nconv, vecs[i].exp_convst);
            check("sclk_rises", i, nrise, 12);
            check("sclk_high_cycles", i, nhigh, vecs[i].exp_high);
            check("din_bits", i, din_bits, {vecs[i].exp_cfg, 6'b000000});
            check("data_valid", i, dv, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check("data", i, d, vecs[i].exp_data);
                check("data_ch", i, dc, vecs[i].exp_ch);
            end
        end

        // Reset during SHIFT bit 7
        @(negedge clk);
        start0 = 1'b1; ch0 = 3'd2; word0 = 12'hABC;
        @(negedge clk);
        start0 = 1'b0;
        rises = 0;
        for (int cyc = 0; cyc < 400 && rises < 8; cyc++) begin
            @(negedge clk);
            if (sclk0) begin
                // count a rise only on the first high sample of a period
                if (dut0.div_cnt_q == 8'd0) rises++;
            end
        end
        check("pre_rst_busy_sclk", 0, {busy0, sclk0}, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("midrst_outs", 0, {busy0, dv0, data0, dch0, convst0, sclk0, din0}, 0);
        @(negedge clk);
        check("midrst_hold", 0, {busy0, dv0, convst0, sclk0}, 0);
        rst = 1'b0;

        // First request after reset primes again
        run_frame(0, 3'd5, 12'h0F0, lat, nconv, nrise, nhigh, din_bits, dv, d, dc);
        check("reprime_valid", 0, dv, 1'b0);
        check("reprime_latency", 0, lat, 129);

        // start held high for 500 cycles: back-to-back frames, one idle between
        exp_b2b_ch[0] = 3'd5; exp_b2b_ch[1] = 3'd0;
        exp_b2b_ch[2] = 3'd2; exp_b2b_ch[3] = 3'd4;
        ndv = 0; nlow = 0;
        @(negedge clk);
        start0 = 1'b1;
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!busy0 && cyc < 500) nlow++;
            if (dv0) begin
                if (ndv < 4) begin
                    dv_pos[ndv] = cyc;
                    dv_ch[ndv]  = dch0;
                end
                ndv++;
            end
            if (cyc < 500) ch0 = 3'(cyc);
            else           start0 = 1'b0;
            @(negedge clk);
        end
        check("b2b_dv_count", 0, ndv, 4);
        check("b2b_busy_low_cycles", 0, nlow, 7);
        check("b2b_end_busy", 0, busy0, 1'b0);
        for (int k = 0; k < 4 && k < ndv; k++) begin
            check("b2b_dv_pos", k, dv_pos[k], 129 + 130 * k);
            check("b2b_data_ch", k, dv_ch[k], exp_b2b_ch[k]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_ltc2308_ctrl.md
ADC_LTC2308_CTRL -- requirements
Module: adc_ltc2308_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: CLOCK_50 cycles per ADC_SCLK half-period, legal range 1..255.
REQ-002 SHALL have parameter CONV_CYCLES, default 80: CLOCK_50 cycles that ADC_CONVST is held high (1.6 us at 50 MHz), legal range 1..1023.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: conversion request, sampled only while busy=0.
REQ-006 SHALL have port ch, input, 3 bits: single-ended channel for the request; captured with start.
REQ-007 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until the request completes.
REQ-008 SHALL have port data_valid, output, 1 bit: one-cycle strobe marking data and data_ch as valid.
REQ-009 SHALL have port data, output, 12 bits: conversion result, straight binary.
REQ-010 SHALL have port data_ch, output, 3 bits: channel that data belongs to.
REQ-011 SHALL have port ADC_CONVST, output, 1 bit: LTC2308 CONVST; the top level drives ADC_CS_N from it.
REQ-012 SHALL have port ADC_SCLK, output, 1 bit: serial clock.
REQ-013 SHALL have port ADC_DIN, output, 1 bit: serial configuration out to the ADC.
REQ-014 SHALL have port ADC_DOUT, input, 1 bit: serial result in; already synchronous to ADC_SCLK, no synchronizer.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, SHIFT, DONE.
REQ-016 IDLE: if start=1, SHALL capture ch into cfg_ch, enter CONV next cycle and set busy=1; if start=0, SHALL stay in IDLE.
REQ-017 CONV: ADC_CONVST=1 for exactly CONV_CYCLES cycles, ADC_SCLK=0, then SHALL enter SHIFT.
REQ-018 SHIFT: ADC_CONVST=0; 12 ADC_SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high, 24*CLK_DIV cycles total; then SHALL enter DONE.
REQ-019 SHALL use config word {S/D=1, O/S=cfg_ch[0], S1=cfg_ch[2], S0=cfg_ch[1], UNI=1, SLP=0}, sent MSB first.
REQ-020 ADC_DIN SHALL present config bit k from the start of SCLK period k for k=0..5, and 0 for periods 6..11; ADC_DIN SHALL change only while ADC_SCLK is low.
REQ-021 SHALL shift ADC_DOUT into the result register, MSB first, in the cycle that ADC_SCLK goes 0->1; 12 samples per frame.
REQ-022 LTC2308 pipelining: the frame shifts out the conversion configured by the previous frame, so data_ch SHALL equal the cfg_ch of the previous request.
REQ-023 DONE lasts 1 cycle: data and data_ch updated; data_valid=1 unless this is the first frame after reset; busy=0 in that same cycle; next state IDLE.
REQ-024 data_valid SHALL be suppressed for the first frame after reset (priming frame); a prime flag SHALL be set at the end of that frame.
REQ-025 data and data_ch SHALL hold their values until the next DONE.
REQ-026 start while busy=1 SHALL be ignored: not queued, no effect on cfg_ch.
REQ-027 start in the DONE cycle SHALL be ignored (FSM not yet in IDLE); start in the first IDLE cycle after DONE SHALL be accepted.
REQ-028 Latency from the start-accept cycle to data_valid SHALL be 1+CONV_CYCLES+24*CLK_DIV cycles (129 at defaults).
REQ-029 Changes on ch while busy=1 SHALL NOT affect the frame in progress.

Reset
REQ-030 RESET=1 SHALL asynchronously force: state IDLE, busy=0, data_valid=0, data=0, data_ch=0, ADC_CONVST=0, ADC_SCLK=0, ADC_DIN=0, prime flag cleared, all counters 0.
REQ-031 RESET asserted mid-CONV or mid-SHIFT SHALL abort the frame with no data_valid; the next request after reset SHALL be treated as a priming frame.
REQ-032 SHALL leave IDLE no earlier than the first rising edge after RESET deasserts with start=1.

Verification
REQ-033 Reset then start with ch=3 (priming), then start with ch=5, ADC model returns 0xA5C -> first frame: no data_valid; second frame: data_valid with data=0xA5C, data_ch=3.
REQ-034 Accept-to-data_valid count at defaults -> 129 cycles; ADC_CONVST high for exactly 80 cycles; exactly 12 ADC_SCLK rising edges per frame; half-period of 2 cycles.
REQ-035 ch=6 -> ADC_DIN bits sampled on the first 6 SCLK rises = 1,0,1,1,1,0; next 6 bits = 0.
REQ-036 start pulsed every cycle for 500 cycles -> frames back-to-back with one IDLE cycle between; no request queued; busy never glitches low mid-frame.
REQ-037 RESET asserted at SHIFT bit 7 -> all outputs 0 in the same cycle, no data_valid; the following request primes again (no data_valid).
REQ-038 CLK_DIV=1, CONV_CYCLES=1 -> latency 26 cycles; data bits 0xFFF and 0x000 captured correctly.
